// File: rtl/rf_wr_arbiter_2r.sv
// Write-port owner for an 8x8 register file: clears every entry after reset, then
// round-robin arbitrates two valid/ready requesters. Optional RF_WR_ARB_CONFLICT_CNT_EN adds conflict_cnt.
//   state | meaning
//   INIT  | writing INIT_VAL to entries 0..NUM_ENTRIES-1
//   RUN   | arbitrating req0/req1 onto the write port
module rf_wr_arbiter_2r #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter logic [7:0]  INIT_VAL    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_val,
  input  logic [2:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_rdy,
  input  logic       req1_val,
  input  logic [2:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_rdy,
  output logic       rf_write_en,
  output logic [2:0] rf_write_addr,
  output logic [7:0] rf_write_data,
`ifdef RF_WR_ARB_CONFLICT_CNT_EN
  output logic [7:0] conflict_cnt,
`endif
  output logic       init_done
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] LAST_ADDR = 3'(NUM_ENTRIES - 1);

  state_t     state, state_nxt;
  logic [2:0] init_addr;
  logic       prio;
  logic       grant_vld;
  logic       grant_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_addr == LAST_ADDR) state_nxt = RUN;
  end

  // Round-robin: a lone requester always wins; on conflict prio picks the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (state == RUN) begin
      if (req0_val && req1_val) begin
        grant_vld = 1'b1;
        grant_idx = prio;
      end else if (req0_val) begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end else if (req1_val) begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_addr = 3'd0;
    rf_write_data = 8'd0;
    req0_rdy      = 1'b0;
    req1_rdy      = 1'b0;
    init_done     = 1'b0;
    if (!reset) begin
      if (state == INIT) begin
        rf_write_en   = 1'b1;
        rf_write_addr = init_addr;
        rf_write_data = INIT_VAL;
      end else begin
        init_done = 1'b1;
        if (grant_vld) begin
          rf_write_en   = 1'b1;
          req0_rdy      = ~grant_idx;
          req1_rdy      = grant_idx;
          rf_write_addr = grant_idx ? req1_addr : req0_addr;
          rf_write_data = grant_idx ? req1_data : req0_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_addr <= 3'd0;
      prio      <= 1'b0;
    end else begin
      if (state == INIT) init_addr <= init_addr + 3'd1;
      if (grant_vld)     prio      <= ~grant_idx;
    end
  end

`ifdef RF_WR_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      conflict_cnt <= 8'd0;
    else if (state == RUN && req0_val && req1_val && conflict_cnt != 8'hFF)
      conflict_cnt <= conflict_cnt + 8'd1;
  end
`endif

endmodule
